uart_tx_fsm: RTL
================

UART_TX_FSM -- requirements
Module: uart_tx_fsm

Interface
REQ-001 The block SHALL have parameter OVERSAMPLE, default 16, giving baud_tick pulses per bit period (legal 8..16).
REQ-002 The block SHALL have parameter STOP_BITS, default 1, giving the number of stop bit periods (legal 1 or 2).
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  system clock, rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 baud_tick  input  1  one-clk pulse at OVERSAMPLE x baud rate.
REQ-007 parity_bit_mode  input  1  CPU parity enable (1 = parity bit sent).
REQ-008 fifo_empty  input  1  TX FIFO empty; FIFO is first-word-fall-through and its head feeds the shift register data_in.
REQ-009 start_bit, data_on_trans, parity_bit, stop_bit  input  1 each  stage flags returned by shift_register_wr.
REQ-010 ctrl_shift_register  output  4  one-hot stage select: 0000 idle, 0001 start, 0010 data, 0100 parity, 1000 stop.
REQ-011 tick_count  output  4  data bit index 1..8 (selects data_in[tick_count-1]); 0 outside DATA.
REQ-012 fifo_rd  output  1  one-clk pop pulse to TX FIFO.
REQ-013 tx_busy  output  1  high in every state except IDLE.
REQ-014 tx_done  output  1  one-clk pulse on frame completion.
REQ-015 tx_err  output  1  one-clk pulse on stage-flag mismatch abort.

Function
REQ-016 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP; ctrl_shift_register is a registered decode of state.
REQ-017 A 4-bit sample_cnt SHALL count baud_tick within a bit; "bit end" = baud_tick && sample_cnt == OVERSAMPLE-1; sample_cnt clears at bit end and on every state entry.
REQ-018 IDLE -> START on the clk after fifo_empty is sampled low; parity_bit_mode SHALL be latched on this transition and held for the whole frame.
REQ-019 START -> DATA at bit end; tick_count SHALL load 1 on DATA entry.
REQ-020 In DATA, each bit end SHALL increment tick_count while below 8; at bit end with tick_count == 8, exit to PARITY if latched parity mode = 1, else STOP; tick_count = 0 on exit.
REQ-021 PARITY -> STOP at bit end.
REQ-022 STOP SHALL last STOP_BITS bit periods; at final bit end fifo_rd and tx_done pulse for exactly that one cycle and state -> IDLE.
REQ-023 Each frame SHALL pop exactly one FIFO entry; no pop on abort or reset.
REQ-024 Flag check: at each bit end the flag of the current stage (start_bit/data_on_trans/parity_bit/stop_bit) SHALL be 1; if 0, the FSM SHALL pulse tx_err, go to IDLE, and not pop.
REQ-025 Back-to-back frames SHALL spend exactly one clk in IDLE between stop end and next START.
REQ-026 baud_tick asserted in the same cycle as the IDLE -> START transition SHALL not be counted.
REQ-027 fifo_empty rising mid-frame SHALL not affect the frame in progress.
REQ-028 tx_done and tx_err SHALL never assert in the same cycle.

Reset
REQ-029 On rst assertion all outputs SHALL go immediately to: ctrl_shift_register 0000, tick_count 0, fifo_rd 0, tx_busy 0, tx_done 0, tx_err 0; state IDLE, sample_cnt 0.
REQ-030 Reset mid-frame SHALL abandon the frame without pop; after deassertion a non-empty FIFO restarts the same entry from START.

Verification
REQ-031 OVERSAMPLE=16, parity off, one entry 0xA5, flags modelled by shift_register_wr -> ctrl 0001/0010/1000 for 16/128/16 baud_ticks, tick_count 1..8, one fifo_rd coincident with tx_done, tx_busy low after.
REQ-032 parity_bit_mode=1, entry 0x03 -> 0100 stage present for 16 baud_ticks between DATA and STOP; frame = 11 bit periods; parity_bit_mode toggled mid-frame has no effect.
REQ-033 Two entries queued -> two frames, two fifo_rd pulses, exactly one IDLE clk between them.
REQ-034 rst pulsed while tick_count = 4 -> all outputs at reset values in same cycle, no fifo_rd; after release frame restarts with tick_count 1 in DATA.
REQ-035 data_on_trans forced 0 during DATA -> tx_err pulse at first data bit end, ctrl 0000 next cycle, no fifo_rd, no tx_done.
REQ-036 STOP_BITS=2 -> 1000 held for 32 baud_ticks, fifo_rd only at second stop bit end.

Source files
------------

// File: rtl/uart_tx_fsm.sv
// UART transmit sequencer: steps start/data/parity/stop on baud_tick,
// steers the external shift register and pops one FIFO entry per frame.
module uart_tx_fsm #(
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic       parity_bit_mode,
    input  logic       fifo_empty,
    input  logic       start_bit,
    input  logic       data_on_trans,
    input  logic       parity_bit,
    input  logic       stop_bit,
    output logic [3:0] ctrl_shift_register,
    output logic [3:0] tick_count,
    output logic       fifo_rd,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    localparam logic [3:0] LAST_SAMPLE = 4'(OVERSAMPLE - 1);
    localparam logic       LAST_STOP   = 1'(STOP_BITS - 1);

    state_e     state_q, state_d;
    logic [3:0] sample_q, sample_d;
    logic [3:0] tick_q, tick_d;
    logic [3:0] ctrl_q, ctrl_d;
    logic       stop_q, stop_d;
    logic       par_q, par_d;
    logic       busy_q, busy_d;
    logic       bit_end;
    logic       flag_ok;

    assign bit_end = baud_tick && (sample_q == LAST_SAMPLE);

    always_comb begin
        flag_ok = 1'b1;
        unique case (state_q)
            S_START:  flag_ok = start_bit;
            S_DATA:   flag_ok = data_on_trans;
            S_PARITY: flag_ok = parity_bit;
            S_STOP:   flag_ok = stop_bit;
            default:  flag_ok = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        stop_d  = stop_q;
        par_d   = par_q;
        fifo_rd = 1'b0;
        tx_done = 1'b0;
        tx_err  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d = S_START;
                    par_d   = parity_bit_mode;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    tick_d  = 4'd1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (tick_q < 4'd8) begin
                        tick_d = tick_q + 4'd1;
                    end else begin
                        tick_d  = 4'd0;
                        state_d = par_q ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (stop_q == LAST_STOP) begin
                        stop_d  = 1'b0;
                        state_d = S_IDLE;
                        fifo_rd = 1'b1;
                        tx_done = 1'b1;
                    end else begin
                        stop_d = stop_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A missing stage flag overrides any normal exit, including the pop.
        if (bit_end && !flag_ok) begin
            state_d = S_IDLE;
            tick_d  = 4'd0;
            stop_d  = 1'b0;
            fifo_rd = 1'b0;
            tx_done = 1'b0;
            tx_err  = 1'b1;
        end
    end

    always_comb begin
        sample_d = sample_q;
        if (state_d != state_q || state_q == S_IDLE) begin
            sample_d = 4'd0;
        end else if (baud_tick) begin
            sample_d = bit_end ? 4'd0 : sample_q + 4'd1;
        end
    end

    always_comb begin
        ctrl_d = 4'b0000;
        unique case (state_d)
            S_START:  ctrl_d = 4'b0001;
            S_DATA:   ctrl_d = 4'b0010;
            S_PARITY: ctrl_d = 4'b0100;
            S_STOP:   ctrl_d = 4'b1000;
            default:  ctrl_d = 4'b0000;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sample_q <= 4'd0;
            tick_q   <= 4'd0;
            stop_q   <= 1'b0;
            par_q    <= 1'b0;
            ctrl_q   <= 4'b0000;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            tick_q   <= tick_d;
            stop_q   <= stop_d;
            par_q    <= par_d;
            ctrl_q   <= ctrl_d;
            busy_q   <= busy_d;
        end
    end

    assign ctrl_shift_register = ctrl_q;
    assign tick_count          = tick_q;
    assign tx_busy             = busy_q;

endmodule
